vram_arbiter: RTL and testbench
===============================

# vram_arbiter

Shares one single-port synchronous video RAM (8-bit pixels, 640×480) between the VGA scanout and the CPU. Scanout fetches have absolute priority and are never delayed. CPU accesses use a req/ack handshake and are slotted into cycles where scanout does not fetch. The block sits between the VGA timing generator, the CPU bus bridge and the VRAM macro.

## Interface
- ADDR_W, 19, VRAM address width
- DATA_W, 8, pixel/data width
- H_SIZE, 640, visible pixels per line
- V_SIZE, 480, visible lines
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- scan_fetch  in  1  scanout requests the pixel at scan_x/scan_y this cycle
- scan_x  in  10  pixel column
- scan_y  in  10  pixel row
- blank  in  1  vertical blanking indicator (used only with VRAM_BLANK_ONLY_EN)
- scan_col  out  DATA_W  pixel data returned to scanout
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  linear pixel address
- cpu_wdata  in  DATA_W  write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  read data, valid while cpu_ack = 1 and held afterwards
- mem_addr  out  ADDR_W  VRAM address
- mem_we  out  1  VRAM write enable
- mem_wdata  out  DATA_W  VRAM write data
- mem_rdata  in  DATA_W  VRAM read data, valid one cycle after the address

## Operation
- Scan slot: scan_fetch=1, scan_x<H_SIZE and scan_y<V_SIZE. Otherwise no scan slot.
- Scan address: scan_y*640+scan_x, computed as (y<<9)+(y<<7)+x in 19 bits.
- In a scan slot, mem_addr takes the scan address and mem_we=0. The cycle is combinational from the inputs.
- scan_col: a register tracks whether the previous cycle was a scan slot. If it was, scan_col=mem_rdata. Otherwise scan_col holds its last value.
- Free slot: no scan slot this cycle. With the macro defined, blank=1 is also required.
- CPU FSM states: IDLE, WAIT, DATA, ACK.
  - IDLE: on cpu_req=1, latch we/addr/wdata.
    - If the latched address is ≥ 307200, go to ACK. No memory cycle occurs, and a read returns 0.
    - Otherwise go to WAIT.
  - WAIT: drive the latched request onto mem_* in the first free slot.
    - A write goes to ACK.
    - A read goes to DATA.
    - With no free slot, stay in WAIT.
  - DATA: capture mem_rdata into cpu_rdata, then go to ACK.
  - ACK: cpu_ack=1 for exactly one cycle, then go to IDLE.
- Changes to cpu_req, cpu_addr or cpu_wdata after latching are ignored. Transactions cannot be aborted.
- If cpu_req is still 1 in the cycle after ACK, IDLE starts a new transaction. Back-to-back accesses are allowed.
- When neither side owns the bus: mem_we=0, mem_addr=0, mem_wdata=0.

## Timing
- Reset values:
  - cpu_ack=0, cpu_rdata=0, scan_col=0, FSM=IDLE.
  - mem_we is forced to 0 in every cycle where reset=1.
- Reset mid-transaction abandons the access without an ack.
- Scanout latency: scan_col is valid 1 cycle after the scan slot.
- CPU write, free bus: req sampled in cycle 0, memory write in cycle 1, cpu_ack in cycle 2.
- CPU read, free bus: req in cycle 0, issue in cycle 1, capture in cycle 2, cpu_ack in cycle 3.
- Each blocked cycle in WAIT adds one cycle of latency.
- Out-of-range access: cpu_ack in cycle 1.
- Scan slot and CPU issue in the same cycle: scanout wins and the CPU stays in WAIT. The two never drive mem_* together.
- During continuous active fetch, CPU access waits for horizontal blanking. There is no starvation, because blanking occurs on every line.

## Configuration
- VRAM_BLANK_ONLY_EN
  - Defined: CPU issues only when blank=1 and there is no scan slot. This avoids mid-frame tearing.
  - Undefined: the blank input is ignored, and the CPU uses any non-scan cycle, including horizontal blanking.

## Structure
- Package vram_pkg holds:
  - H_SIZE, V_SIZE and VRAM_DEPTH=307200
  - the CPU FSM state enum
- Sub-module vram_scan_addr: combinational x,y → linear address plus the in-range check.

## Test plan
- Reset held 3 cycles during a WAIT write: mem_we stays 0, no cpu_ack, FSM returns to IDLE.
- No scanout, CPU write 0x5A to address 1000, then read address 1000:
  - write ack in cycle 2
  - read ack in cycle 3 with cpu_rdata=0x5A
- Scan fetch at x=639, y=479: mem_addr=307199, mem_we=0, and scan_col equals the RAM content one cycle later.
- scan_fetch held high for 20 cycles while a CPU read is pending: the CPU issues in the first cycle scan_fetch=0, and cpu_ack follows 2 cycles after that.
- CPU read at address 307200: cpu_ack in cycle 1, cpu_rdata=0, no memory access.
- With VRAM_BLANK_ONLY_EN, blank=0 and scan_fetch=0: the CPU request stays in WAIT and issues in the first cycle blank=1.

Source files
------------

// File: rtl/vram_pkg.sv
// vram_pkg: shared VRAM geometry and the CPU access FSM state type.
package vram_pkg;
    localparam logic [9:0]  H_SIZE     = 10'd640;
    localparam logic [9:0]  V_SIZE     = 10'd480;
    localparam logic [18:0] VRAM_DEPTH = 19'd307200;
    typedef enum logic [1:0] {IDLE, WAIT, DATA, ACK} cpu_state_t;
endpackage

// File: rtl/vram_scan_addr.sv
// vram_scan_addr: scanout x,y to linear VRAM address (y*640+x) plus visible-area check.
module vram_scan_addr #(
    parameter logic [9:0] H_SIZE = vram_pkg::H_SIZE,
    parameter logic [9:0] V_SIZE = vram_pkg::V_SIZE
) (
    input  logic        fetch,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    output logic        slot,
    output logic [18:0] addr
);
    assign slot = fetch && (x < H_SIZE) && (y < V_SIZE);
    assign addr = {y, 9'b0} + {2'b0, y, 7'b0} + {9'b0, x};
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port VRAM shared by scanout (absolute priority) and a CPU req/ack port.
// VRAM_BLANK_ONLY_EN restricts CPU accesses to vertical blanking.
module vram_arbiter #(
    parameter int         ADDR_W = 19,
    parameter int         DATA_W = 8,
    parameter logic [9:0] H_SIZE = vram_pkg::H_SIZE,
    parameter logic [9:0] V_SIZE = vram_pkg::V_SIZE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scan_fetch,
    input  logic [9:0]        scan_x,
    input  logic [9:0]        scan_y,
    input  logic              blank,
    output logic [DATA_W-1:0] scan_col,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    import vram_pkg::*;

    cpu_state_t        state, next;
    logic              scan_slot, free_slot, issue, prev_scan, lat_we, out_of_range;
    logic [18:0]       scan_addr;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata, col_q;

    vram_scan_addr #(.H_SIZE(H_SIZE), .V_SIZE(V_SIZE)) u_scan (
        .fetch(scan_fetch),
        .x(scan_x),
        .y(scan_y),
        .slot(scan_slot),
        .addr(scan_addr)
    );

`ifdef VRAM_BLANK_ONLY_EN
    assign free_slot = !scan_slot && blank;
`else
    logic unused_blank;
    assign unused_blank = blank;
    assign free_slot = !scan_slot;
`endif

    assign issue        = (state == WAIT) && free_slot;
    assign out_of_range = cpu_addr >= ADDR_W'(VRAM_DEPTH);
    assign mem_addr     = scan_slot ? ADDR_W'(scan_addr) : issue ? lat_addr : '0;
    assign mem_we       = issue && lat_we && !reset;
    assign mem_wdata    = issue ? lat_wdata : '0;
    assign cpu_ack      = state == ACK;
    // Read data arrives the cycle after a scan slot; otherwise hold the last pixel.
    assign scan_col     = prev_scan ? mem_rdata : col_q;

    always_comb begin
        next = state;
        case (state)
            IDLE:    if (cpu_req) next = out_of_range ? ACK : WAIT;
            WAIT:    if (issue) next = lat_we ? ACK : DATA;
            DATA:    next = ACK;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_scan <= 1'b0;
            col_q     <= '0;
            cpu_rdata <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            prev_scan <= scan_slot;
            col_q     <= scan_col;
            if (state == IDLE && cpu_req) begin
                lat_we    <= cpu_we;
                lat_addr  <= cpu_addr;
                lat_wdata <= cpu_wdata;
            end
            if (state == DATA)
                cpu_rdata <= mem_rdata;
            else if (state == IDLE && cpu_req && !cpu_we && out_of_range)
                cpu_rdata <= '0;
        end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed scoreboard bench for vram_arbiter with a behavioural VRAM.
module tb_vram_arbiter;
    import vram_pkg::*;

    logic        clk = 0, reset = 1, scan_fetch = 0, blank = 1;
    logic [9:0]  scan_x = 0, scan_y = 0;
    logic        cpu_req = 0, cpu_we = 0, cpu_ack, mem_we;
    logic [18:0] cpu_addr = 0, mem_addr;
    logic [7:0]  cpu_wdata = 0, cpu_rdata, scan_col, mem_wdata, mem_rdata;
    logic [7:0]  ram [307200];
    int          nvec = 0, nerr = 0;
    logic        first_we;
    logic [18:0] first_addr;

    typedef struct {
        int         lat;
        logic [7:0] rdata;
        logic       is_read;
    } exp_t;
    exp_t sb[$];

    vram_arbiter dut (
        .clk(clk), .reset(reset), .scan_fetch(scan_fetch), .scan_x(scan_x), .scan_y(scan_y),
        .blank(blank), .scan_col(scan_col), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    initial for (int i = 0; i < 307200; i++) ram[i] = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    // Counts cycles from the request cycle until cpu_ack, then scores against the queue head.
    task automatic wait_ack(input string tag);
        int   cyc = 0;
        exp_t e;
        do begin
            step;
            cyc++;
            if (cyc == 1) begin
                first_we   = mem_we;
                first_addr = mem_addr;
            end
        end while (!cpu_ack && cyc < 60);
        cpu_req = 0;
        e = sb.pop_front();
        check({tag, "_latency"}, cyc, e.lat);
        if (e.is_read) check({tag, "_rdata"}, cpu_rdata, e.rdata);
    endtask

    task automatic cpu_access(input string tag, input logic we, input logic [18:0] addr,
                              input logic [7:0] wdata, input int lat, input logic [7:0] rdata);
        step;
        cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        sb.push_back('{lat, rdata, !we});
        wait_ack(tag);
        if (addr < VRAM_DEPTH) begin
            check({tag, "_issue_we"}, first_we, we);
            check({tag, "_issue_addr"}, first_addr, addr);
        end else begin
            check({tag, "_no_mem_we"}, first_we, 0);
            check({tag, "_no_mem_addr"}, first_addr, 0);
        end
    endtask

    initial begin
        repeat (3) step;
        check("rst_ack", cpu_ack, 0);
        check("rst_rdata", cpu_rdata, 0);
        check("rst_scan_col", scan_col, 0);
        check("rst_mem_we", mem_we, 0);
        reset = 0;

        // A write parked in WAIT behind scanout, then hit by a 3-cycle reset.
        step;
        scan_fetch = 1; scan_x = 0; scan_y = 0;
        cpu_req = 1; cpu_we = 1; cpu_addr = 19'd2000; cpu_wdata = 8'hEE;
        step;
        check("wait_blocked_we", mem_we, 0);
        step;
        reset = 1; scan_fetch = 0; cpu_req = 0;
        #1;
        check("reset_gates_we", mem_we, 0);
        check("reset_no_ack0", cpu_ack, 0);
        for (int i = 0; i < 2; i++) begin
            step;
            check("reset_we_held", mem_we, 0);
            check("reset_no_ack", cpu_ack, 0);
        end
        reset = 0;
        step;
        check("post_reset_ack", cpu_ack, 0);
        check("post_reset_idle_addr", mem_addr, 0);
        check("post_reset_idle_we", mem_we, 0);

        cpu_access("wr1000", 1, 19'd1000, 8'h5A, 2, 8'h00);
        cpu_access("rd1000", 0, 19'd1000, 8'h00, 3, 8'h5A);
        cpu_access("rd2000_aborted", 0, 19'd2000, 8'h00, 3, 8'h00);

        // Last visible pixel.
        cpu_access("wr_last", 1, 19'd307199, 8'h77, 2, 8'h00);
        step;
        scan_fetch = 1; scan_x = 10'd639; scan_y = 10'd479;
        #1;
        check("scan_last_addr", mem_addr, 307199);
        check("scan_last_we", mem_we, 0);
        step;
        scan_fetch = 0;
        check("scan_col_last", scan_col, 8'h77);
        step;
        check("scan_col_hold", scan_col, 8'h77);
        scan_fetch = 1; scan_x = 10'd640; scan_y = 10'd0;
        #1;
        check("scan_x_oob_addr", mem_addr, 0);
        scan_x = 10'd0; scan_y = 10'd480;
        #1;
        check("scan_y_oob_addr", mem_addr, 0);
        scan_fetch = 0;

        // CPU read pending under 20 cycles of active fetch.
        cpu_access("wr5000", 1, 19'd5000, 8'h33, 2, 8'h00);
        step;
        scan_fetch = 1; scan_y = 10'd1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 19'd5000;
        for (int i = 0; i < 20; i++) begin
            scan_x = 10'(i);
            #1;
            check("busy_scan_addr", mem_addr, 640 + i);
            check("busy_no_ack", cpu_ack, 0);
            step;
        end
        scan_fetch = 0;
        #1;
        check("busy_issue_addr", mem_addr, 5000);
        check("busy_issue_we", mem_we, 0);
        sb.push_back('{2, 8'h33, 1'b1});
        wait_ack("busy_rd5000");

        cpu_access("rd_oob", 0, 19'd307200, 8'h00, 1, 8'h00);

`ifdef VRAM_BLANK_ONLY_EN
        step;
        blank = 0;
        cpu_req = 1; cpu_we = 1; cpu_addr = 19'd6000; cpu_wdata = 8'h44;
        for (int i = 0; i < 5; i++) begin
            step;
            check("blank_hold_we", mem_we, 0);
            check("blank_hold_ack", cpu_ack, 0);
        end
        blank = 1;
        #1;
        check("blank_issue_we", mem_we, 1);
        check("blank_issue_addr", mem_addr, 6000);
        sb.push_back('{1, 8'h00, 1'b0});
        wait_ack("blank_wr6000");
`else
        blank = 0;
        cpu_access("hblank_wr6000", 1, 19'd6000, 8'h44, 2, 8'h00);
        blank = 1;
`endif
        cpu_access("rd6000", 0, 19'd6000, 8'h00, 3, 8'h44);
        check("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
